// File: rtl/btn_pkg.sv
// Shared types and default 50 MHz timing for the key front-end.
// State encoding is common to the repeat and single-pulse builds.
package btn_pkg;

    // BTN_DELAY doubles as the plain "key down" state when auto-repeat is not built.
    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_DELAY  = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_t;

    localparam int unsigned DEF_N_BTN        = 3;
    localparam int unsigned DEF_SAMPLE_DIV   = 500000;
    localparam int unsigned DEF_DEB_SAMPLES  = 3;
    localparam int unsigned DEF_REPEAT_DELAY = 50;
    localparam int unsigned DEF_REPEAT_RATE  = 10;

endpackage

// File: rtl/btn_chan.sv
// One key channel: 2-flop synchroniser, tick-driven debounce history,
// press/repeat FSM and the registered one-CLK press pulse.
// Auto-repeat is built only when BTN_REPEAT_EN is defined.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous reset, active-high
//   tick_i  one-CLK sample strobe from the shared divider
//   nbtn_i  raw key, active-low, asynchronous
//   press_o one-CLK pulse per accepted press (and per repeat)
//   held_o  debounced level, 1 = key down
module btn_chan
    import btn_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES  = DEF_DEB_SAMPLES,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic nbtn_i,
    output logic press_o,
    output logic held_o
);

    if (DEB_SAMPLES < 2 || DEB_SAMPLES > 8 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("btn_chan: parameter out of range");
    end

    // Synchroniser holds the raw (active-low) level; reset = released.
    logic s1_q, s2_q;
    logic down;

    logic [DEB_SAMPLES-1:0] hist_q, hist_d;
    logic                   held_q, held_d;
    btn_state_t             state_q, state_d;
    logic                   press_q, press_d;

`ifdef BTN_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                                   REPEAT_DELAY : REPEAT_RATE;
    // Largest value loaded is RMAX-1.
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic [RW-1:0] rcnt_q, rcnt_d;
`endif

    assign down = ~s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            hist_q  <= '0;
            held_q  <= 1'b0;
            state_q <= BTN_IDLE;
            press_q <= 1'b0;
        end else begin
            s1_q    <= nbtn_i;
            s2_q    <= s1_q;
            hist_q  <= hist_d;
            held_q  <= held_d;
            state_q <= state_d;
            press_q <= press_d;
        end
    end

`ifdef BTN_REPEAT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`endif

    // The FSM looks at the debounced level being accepted on this same
    // tick, so the press pulse lands in the CLK right after that tick.
    always_comb begin
        hist_d  = hist_q;
        held_d  = held_q;
        state_d = state_q;
        press_d = 1'b0;
`ifdef BTN_REPEAT_EN
        rcnt_d  = rcnt_q;
`endif
        if (tick_i) begin
            hist_d = {hist_q[DEB_SAMPLES-2:0], down};
            if (&hist_d) begin
                held_d = 1'b1;
            end else if (~|hist_d) begin
                held_d = 1'b0;
            end

            unique case (state_q)
                BTN_IDLE: begin
                    if (held_d) begin
                        press_d = 1'b1;
                        state_d = BTN_DELAY;
`ifdef BTN_REPEAT_EN
                        rcnt_d  = RW'(REPEAT_DELAY - 1);
`endif
                    end
                end
`ifdef BTN_REPEAT_EN
                BTN_DELAY, BTN_REPEAT: begin
                    if (!held_d) begin
                        state_d = BTN_IDLE;
                    end else if (rcnt_q == '0) begin
                        press_d = 1'b1;
                        state_d = BTN_REPEAT;
                        rcnt_d  = RW'(REPEAT_RATE - 1);
                    end else begin
                        rcnt_d  = rcnt_q - RW'(1);
                    end
                end
`else
                BTN_DELAY: begin
                    if (!held_d) begin
                        state_d = BTN_IDLE;
                    end
                end
`endif
                default: state_d = BTN_IDLE;
            endcase
        end
    end

    assign press_o = press_q;
    assign held_o  = held_q;

endmodule

// File: rtl/btn_repeat.sv
// Key front-end: shared sample-tick divider plus one btn_chan per key.
// Optional auto-repeat is compiled in with BTN_REPEAT_EN.
// Ports:
//   CLK      system clock
//   RST      synchronous reset, active-high
//   nBUTTON  raw keys, active-low, asynchronous
//   PRESS    one-CLK pulse per accepted press / repeat
//   HELD     debounced levels, 1 = key down
module btn_repeat
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN        = DEF_N_BTN,
    parameter int unsigned SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int unsigned DEB_SAMPLES  = DEF_DEB_SAMPLES,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] nBUTTON,
    output logic [N_BTN-1:0] PRESS,
    output logic [N_BTN-1:0] HELD
);

    localparam int unsigned CW = $clog2(SAMPLE_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    assign tick = (cnt_q == CW'(SAMPLE_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_chan #(
            .DEB_SAMPLES (DEB_SAMPLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_chan (
            .clk_i  (CLK),
            .rst_i  (RST),
            .tick_i (tick),
            .nbtn_i (nBUTTON[i]),
            .press_o(PRESS[i]),
            .held_o (HELD[i])
        );
    end

endmodule

// File: tb/tb_btn_repeat.sv
// Scoreboard bench for btn_repeat (SAMPLE_DIV=4, DEB_SAMPLES=3,
// REPEAT_DELAY=5, REPEAT_RATE=2); repeat expectations follow BTN_REPEAT_EN.
module tb_btn_repeat;

    localparam int unsigned NB = 3;

    typedef struct {
        int unsigned    cyc;
        logic [NB-1:0]  val;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [NB-1:0] nBUTTON = '1;
    logic [NB-1:0] PRESS;
    logic [NB-1:0] HELD;

    always #5 CLK = ~CLK;

    btn_repeat #(
        .N_BTN       (NB),
        .SAMPLE_DIV  (4),
        .DEB_SAMPLES (3),
        .REPEAT_DELAY(5),
        .REPEAT_RATE (2)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .nBUTTON(nBUTTON),
        .PRESS  (PRESS),
        .HELD   (HELD)
    );

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned base  = 0;
    exp_t        q[$];

    // Timing after reset: first edge with RST low is base; ticks fall on
    // edges base+3+4k. A key changed before edge base+1 is seen by the
    // debouncer from edge base+3, so the third sample and the press pulse
    // land on edge base+11; repeats follow 5 ticks then every 2 ticks.

    task automatic push(input int unsigned off, input logic [NB-1:0] v);
        exp_t e;
        e.cyc = base + off;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic wait_to(input int unsigned off);
        while (cyc < base + off) @(negedge CLK);
    endtask

    task automatic check_held(input int unsigned off,
                              input logic [NB-1:0] exp,
                              input string name);
        wait_to(off);
        n_cmp++;
        if (HELD !== exp) begin
            n_bad++;
            $display("FAIL %s: HELD=%b expected %b (cyc %0d)",
                     name, HELD, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (PRESS !== '0 || HELD !== '0) begin
            n_bad++;
            $display("FAIL reset: PRESS=%b HELD=%b expected 000/000",
                     PRESS, HELD);
        end
        RST = 1'b0;
        @(posedge CLK);
        #1;
        base = cyc;
    endtask

    // Monitor: every non-zero PRESS must match the head of the queue.
    exp_t me;
    always @(negedge CLK) begin
        if (PRESS !== '0) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_press: PRESS=%b at cyc %0d, none expected",
                         PRESS, cyc);
            end else begin
                me = q.pop_front();
                if (me.cyc != cyc || me.val !== PRESS) begin
                    n_bad++;
                    $display("FAIL press: PRESS=%b at cyc %0d, expected %b at cyc %0d",
                             PRESS, cyc, me.val, me.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with keys up: silence for 40 CLK.
        do_reset();
        check_held(40, 3'b000, "reset_idle");

        // Clean press then early release.
        do_reset();
        nBUTTON = 3'b110;
        push(11, 3'b001);
        check_held(10, 3'b000, "clean_before");
        check_held(11, 3'b001, "clean_held");
        wait_to(12);
        nBUTTON = 3'b111;
        check_held(22, 3'b001, "clean_rel_before");
        check_held(23, 3'b000, "clean_released");
        wait_to(40);

        // Glitch of 6 CLK covers only two ticks.
        do_reset();
        nBUTTON = 3'b110;
        wait_to(6);
        nBUTTON = 3'b111;
        check_held(7, 3'b000, "glitch_t7");
        check_held(11, 3'b000, "glitch_t11");
        check_held(15, 3'b000, "glitch_t15");
        wait_to(40);

        // Hold 60 CLK: press plus repeats until HELD falls on edge 71.
        do_reset();
        nBUTTON = 3'b110;
        push(11, 3'b001);
`ifdef BTN_REPEAT_EN
        push(31, 3'b001);
        push(39, 3'b001);
        push(47, 3'b001);
        push(55, 3'b001);
        push(63, 3'b001);
`endif
        wait_to(60);
        nBUTTON = 3'b111;
        check_held(70, 3'b001, "repeat_rel_before");
        check_held(71, 3'b000, "repeat_released");
        wait_to(110);

        // Keys 0 and 2 together.
        do_reset();
        nBUTTON = 3'b010;
        push(11, 3'b101);
        check_held(11, 3'b101, "simul_held");
        wait_to(12);
        nBUTTON = 3'b111;
        check_held(23, 3'b000, "simul_released");
        wait_to(40);

        // Reset while repeating, key kept down throughout.
        do_reset();
        nBUTTON = 3'b110;
        push(11, 3'b001);
`ifdef BTN_REPEAT_EN
        push(31, 3'b001);
        push(39, 3'b001);
`endif
        wait_to(41);
        do_reset();
        push(11, 3'b001);
`ifdef BTN_REPEAT_EN
        push(31, 3'b001);
        push(39, 3'b001);
        push(47, 3'b001);
`endif
        check_held(10, 3'b000, "midhold_before");
        check_held(11, 3'b001, "midhold_held");
        wait_to(40);
        nBUTTON = 3'b111;
        check_held(51, 3'b000, "midhold_released");
        wait_to(90);

        repeat (5) @(negedge CLK);
        while (q.size() != 0) begin
            me = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_press: expected %b at cyc %0d never seen",
                     me.val, me.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
